// File: rtl/adc_frame_streamer_if.sv
// rtl/adc_frame_streamer_if.sv - AXI4-Stream sample link from the frame streamer to the FFT core
interface adc_frame_streamer_if;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_frame_streamer.sv
// rtl/adc_frame_streamer.sv - ADC clocking, frame capture into RAM and AXI4-Stream playout to the FFT
module adc_frame_streamer #(
  parameter int FFT_POINTS    = 1024,
  parameter int ADDR_W        = 10,
  parameter int DIV_HALF      = 13,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input  logic                 clk_27M,
  input  logic                 rst_n,
  input  logic [7:0]           ad_data_in,
  input  logic                 start,
  input  logic                 continuous,
  output logic                 ad_clk,
  adc_frame_streamer_if.master m_axis,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [4:0]        DIV_LAST = 5'(DIV_HALF);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FFT_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [4:0]        divider;
  logic              sample_strobe;
  logic [7:0]        sample_conv;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic              beat_fire;
  logic              last_fire;
  logic              out_load;
  logic              frame_seen;
  logic [7:0]        frame_ram [FFT_POINTS];

  // Sample on the falling toggle: the ADC output has been valid for half an ad_clk period by then.
  assign sample_strobe = (divider == DIV_LAST) && ad_clk;
  assign sample_conv   = OFFSET_BINARY ? (ad_data_in ^ 8'h80) : ad_data_in;

  assign beat_fire = m_axis.tvalid && m_axis.tready;
  assign last_fire = beat_fire && (rd_ptr == LAST_IDX);
  // Read one ahead when the current beat is being accepted so a ready FFT sees 1 sample/cycle.
  assign rd_addr   = rd_ptr + ADDR_W'(beat_fire);
  // The output register only reloads when empty or being drained; this is what holds data during stalls.
  assign out_load  = (state == STREAM) && (!m_axis.tvalid || m_axis.tready);

  assign busy = (state != IDLE);

  // Free-running ADC clock divider, independent of the frame state.
  always_ff @(posedge clk_27M or negedge rst_n) begin
    if (!rst_n) begin
      divider <= '0;
      ad_clk  <= 1'b0;
    end else if (divider == DIV_LAST) begin
      divider <= '0;
      ad_clk  <= ~ad_clk;
    end else begin
      divider <= divider + 5'd1;
    end
  end

  // State register.
  always_ff @(posedge clk_27M or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: auto-restart only once a frame has completed since reset.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start || (continuous && frame_seen)) state_nxt = CAPTURE;
      CAPTURE: if (sample_strobe && (wr_ptr == LAST_IDX)) state_nxt = STREAM;
      STREAM:  if (last_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write and read pointers; each restarts at zero whenever its phase is not active.
  always_ff @(posedge clk_27M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (state != CAPTURE) begin
        wr_ptr <= '0;
      end else if (sample_strobe) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (state != STREAM) begin
        rd_ptr <= '0;
      end else if (out_load) begin
        rd_ptr <= rd_addr;
      end
    end
  end

  // Frame RAM write port; contents need no reset since a frame is always fully rewritten.
  always_ff @(posedge clk_27M) begin
    if ((state == CAPTURE) && sample_strobe) begin
      frame_ram[wr_ptr] <= sample_conv;
    end
  end

  // Synchronous RAM read straight into the AXI output register.
  always_ff @(posedge clk_27M or negedge rst_n) begin
    if (!rst_n) begin
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
    end else if (out_load) begin
      if (last_fire) begin
        m_axis.tvalid <= 1'b0;
        m_axis.tlast  <= 1'b0;
      end else begin
        m_axis.tdata  <= {8'h00, frame_ram[rd_addr]};
        m_axis.tvalid <= 1'b1;
        m_axis.tlast  <= (rd_addr == LAST_IDX);
      end
    end
  end

  // Completion pulse and the "a frame has finished" flag that arms continuous mode.
  always_ff @(posedge clk_27M or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_seen <= 1'b0;
    end else begin
      frame_done <= last_fire;
      if (last_fire) begin
        frame_seen <= 1'b1;
      end
    end
  end

endmodule
